motor_cmd_parser: RTL and testbench
===================================

MOTOR_CMD_PARSER -- requirements
Module: motor_cmd_parser

Interface
REQ-001 SHALL have parameter NUM_MOTORS, default 4, number of addressable motors (1..9).
REQ-002 SHALL have parameter MAX_DIGITS, default 3, maximum magnitude digits per command (1..4).
REQ-003 SHALL have parameter MAX_VALUE, default 255, largest legal magnitude (< 10^MAX_DIGITS).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50_000_000, inter-token timeout in clocks; 0 disables the timeout.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: i_Clk  in  1  rising-edge clock; i_Rst  in  1  async active-low reset.
REQ-006 SHALL have port i_Enable  in  1  one-cycle strobe qualifying i_Dec.
REQ-007 SHALL have port i_Dec  in  4  token: 0-9 digit, 10 SPACE, 11 ENTER, 12 FORWARD, 13 BACKWARD, 14 INVALID.
REQ-008 SHALL have port i_cmd_ready  in  1  consumer accepts the held command.
REQ-009 SHALL have port o_cmd_valid  out  1  command held and stable.
REQ-010 SHALL have port o_motor  out  4  motor number, 1..NUM_MOTORS.
REQ-011 SHALL have port o_direction  out  1  0 = FORWARD, 1 = BACKWARD.
REQ-012 SHALL have port o_value_bcd  out  4*MAX_DIGITS  magnitude as right-aligned BCD with leading zeros.
REQ-013 SHALL have port o_value_bin  out  $clog2(10^MAX_DIGITS)  magnitude in binary.
REQ-014 SHALL have port o_err  out  1  one-cycle error pulse.
REQ-015 SHALL have port o_err_code  out  3  last error cause.
REQ-016 SHALL have port o_drop  out  1  one-cycle pulse for a token discarded while holding.
REQ-017 SHALL have port o_idle  out  1  high when in IDLE, i.e. ready for a new command.

Function
REQ-018 SHALL accept this grammar: motor digit, SPACE, FORWARD|BACKWARD, 1..MAX_DIGITS digits, then terminator SPACE|ENTER.
REQ-019 SHALL implement states IDLE, SP1, SIGN, DIG, HOLD; a token advances state only on a cycle with i_Enable=1.
REQ-020 SHALL transition IDLE->SP1 on a digit in 1..NUM_MOTORS; any other token -> error code 1.
REQ-021 SHALL transition SP1->SIGN on SPACE; other -> error 2.
REQ-022 SHALL transition SIGN->DIG on FORWARD/BACKWARD; other -> error 3.
REQ-023 SHALL in DIG shift each digit into the BCD register and set bin = bin*10 + digit; the first token in DIG being a non-digit -> error 4.
REQ-024 SHALL flag error 5 when a digit arrives after MAX_DIGITS digits, and error 4 for a non-digit, non-terminator token after at least one digit.
REQ-025 SHALL on a terminator: go to HOLD with o_cmd_valid=1 if bin <= MAX_VALUE; otherwise flag error 6.
REQ-026 SHALL register o_cmd_valid and all data outputs on the edge sampling the terminator (zero extra latency); they stay stable while in HOLD.
REQ-027 SHALL leave HOLD for IDLE on the first edge with i_cmd_ready=1, clearing o_cmd_valid on that edge.
REQ-028 SHALL discard any token strobed in HOLD (including the handshake cycle) and pulse o_drop for one cycle.
REQ-029 SHALL on an error pulse o_err, load o_err_code, clear the working registers and return to IDLE on the same edge, so the next token is accepted next cycle.
REQ-030 SHALL count clocks since the last accepted token in SP1/SIGN/DIG; reaching TIMEOUT_CYC-1 -> error 7 and return to IDLE; count is idle in IDLE/HOLD.
REQ-031 SHALL hold o_err_code until the next error or until a successful command reaches HOLD, which sets it to 0.
REQ-032 SHALL treat INVALID (14) and 15 as illegal in every parse state.

Reset
REQ-033 SHALL on i_Rst=0 asynchronously force IDLE, all outputs 0 except o_idle=1, and clear the working registers and the timeout counter.
REQ-034 SHALL abandon any partial or held command on reset, with no o_err pulse.

Verification
REQ-035 SHALL pass: 2,SP,BACKWARD,1,2,5,ENTER -> o_cmd_valid=1, o_motor=2, o_direction=1, o_value_bcd=12'h125, o_value_bin=125.
REQ-036 SHALL pass: 1,SP,FORWARD,7,SP -> o_value_bcd=12'h007, o_value_bin=7; valid held 5 cycles with ready=0, then ready=1 -> IDLE next cycle.
REQ-037 SHALL pass: 3,SP,FORWARD,3,0,0,SP -> o_err pulse, o_err_code=6, no o_cmd_valid.
REQ-038 SHALL pass: 5,... -> error 1; 1,FORWARD -> error 2; 1,SP,1,2,3,4 -> error 3 on the third token.
REQ-039 SHALL pass: with TIMEOUT_CYC=100, send 1,SP then idle 100 cycles -> error 7 at cycle 99 after the SPACE.
REQ-040 SHALL pass: a token during HOLD -> o_drop pulse with outputs unchanged; i_Rst low mid-DIG -> IDLE, o_idle=1.

Source files
------------

// File: rtl/motor_cmd_if.sv
// motor_cmd_if: token strobe in, command/ready handoff and error/drop status out; master drives tokens, slave is the parser
interface motor_cmd_if #(
  parameter int MAX_DIGITS = 3
);
  localparam int BW = $clog2(10 ** MAX_DIGITS);
  logic                    i_Enable;
  logic [3:0]              i_Dec;
  logic                    i_cmd_ready;
  logic                    o_cmd_valid;
  logic [3:0]              o_motor;
  logic                    o_direction;
  logic [4*MAX_DIGITS-1:0] o_value_bcd;
  logic [BW-1:0]           o_value_bin;
  logic                    o_err;
  logic [2:0]              o_err_code;
  logic                    o_drop;
  logic                    o_idle;
  modport master (
    output i_Enable, i_Dec, i_cmd_ready,
    input  o_cmd_valid, o_motor, o_direction, o_value_bcd, o_value_bin,
           o_err, o_err_code, o_drop, o_idle
  );
  modport slave (
    input  i_Enable, i_Dec, i_cmd_ready,
    output o_cmd_valid, o_motor, o_direction, o_value_bcd, o_value_bin,
           o_err, o_err_code, o_drop, o_idle
  );
endinterface

// File: rtl/motor_cmd_parser.sv
// motor_cmd_parser: i_Clk/i_Rst plus bus (tokens in; held command, err/drop pulses, idle out) -- parses "motor SP dir digits term"
module motor_cmd_parser #(
  parameter int          NUM_MOTORS  = 4,
  parameter int          MAX_DIGITS  = 3,
  parameter int          MAX_VALUE   = 255,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input logic        i_Clk,
  input logic        i_Rst,
  motor_cmd_if.slave bus
);
  localparam int BW = $clog2(10 ** MAX_DIGITS);
  localparam int DW = 4 * MAX_DIGITS;
  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam logic [3:0]    NM   = 4'(NUM_MOTORS);
  localparam logic [BW-1:0] MAXV = BW'(MAX_VALUE);
  localparam logic [NW-1:0] MD   = NW'(MAX_DIGITS);
  localparam logic [32:0]   TO   = 33'(TIMEOUT_CYC);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SP1  = 3'd1;
  localparam logic [2:0] SIGN = 3'd2;
  localparam logic [2:0] DIG  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  logic [2:0]    state;
  logic [3:0]    motor_w;
  logic          dir_w;
  logic [DW-1:0] bcd_w;
  logic [BW-1:0] bin_w;
  logic [NW-1:0] ndig;
  logic [31:0]   cnt;
  logic [2:0]    ecode;
  logic          is_dig, is_term, is_dir, busy, tmo;
  always_comb begin
    is_dig  = bus.i_Dec <= 4'd9;
    is_term = bus.i_Dec == 4'd10 || bus.i_Dec == 4'd11;
    is_dir  = bus.i_Dec == 4'd12 || bus.i_Dec == 4'd13;
    busy    = state == SP1 || state == SIGN || state == DIG;
    // cnt holds idle edges so far; the error fires on the edge that brings it to TIMEOUT_CYC-1
    tmo     = TO != 33'd0 && busy && ({1'b0, cnt} + 33'd2 >= TO);
    ecode   = !bus.i_Enable ? (tmo ? 3'd7 : 3'd0) :
              state == IDLE ? ((is_dig && bus.i_Dec != 4'd0 && bus.i_Dec <= NM) ? 3'd0 : 3'd1) :
              state == SP1  ? (bus.i_Dec == 4'd10 ? 3'd0 : 3'd2) :
              state == SIGN ? (is_dir ? 3'd0 : 3'd3) :
              state == DIG  ? (is_dig  ? (ndig == MD ? 3'd5 : 3'd0) :
                               is_term ? (ndig == '0 ? 3'd4 : bin_w > MAXV ? 3'd6 : 3'd0) : 3'd4) :
              3'd0;
  end
  assign bus.o_idle = state == IDLE;
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state           <= IDLE;
      motor_w         <= '0;
      dir_w           <= 1'b0;
      bcd_w           <= '0;
      bin_w           <= '0;
      ndig            <= '0;
      cnt             <= '0;
      bus.o_cmd_valid <= 1'b0;
      bus.o_motor     <= '0;
      bus.o_direction <= 1'b0;
      bus.o_value_bcd <= '0;
      bus.o_value_bin <= '0;
      bus.o_err       <= 1'b0;
      bus.o_err_code  <= '0;
      bus.o_drop      <= 1'b0;
    end else begin
      bus.o_err  <= ecode != 3'd0;
      bus.o_drop <= state == HOLD && bus.i_Enable;
      cnt        <= (busy && !bus.i_Enable && ecode == 3'd0) ? cnt + 32'd1 : '0;
      if (ecode != 3'd0) begin
        bus.o_err_code <= ecode;
        state          <= IDLE;
        motor_w        <= '0;
        dir_w          <= 1'b0;
        bcd_w          <= '0;
        bin_w          <= '0;
        ndig           <= '0;
      end else if (bus.i_Enable && state == IDLE) begin
        motor_w <= bus.i_Dec;
        state   <= SP1;
      end else if (bus.i_Enable && state == SP1) begin
        state <= SIGN;
      end else if (bus.i_Enable && state == SIGN) begin
        dir_w <= bus.i_Dec == 4'd13;
        state <= DIG;
      end else if (bus.i_Enable && state == DIG && is_dig) begin
        bcd_w <= DW'({bcd_w, bus.i_Dec});
        bin_w <= bin_w * BW'(10) + BW'(bus.i_Dec);
        ndig  <= ndig + NW'(1);
      end else if (bus.i_Enable && state == DIG) begin
        bus.o_cmd_valid <= 1'b1;
        bus.o_motor     <= motor_w;
        bus.o_direction <= dir_w;
        bus.o_value_bcd <= bcd_w;
        bus.o_value_bin <= bin_w;
        bus.o_err_code  <= 3'd0;
        state           <= HOLD;
        motor_w         <= '0;
        dir_w           <= 1'b0;
        bcd_w           <= '0;
        bin_w           <= '0;
        ndig            <= '0;
      end else if (state == HOLD && bus.i_cmd_ready) begin
        bus.o_cmd_valid <= 1'b0;
        state           <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_motor_cmd_parser.sv
// tb_motor_cmd_parser: directed and randomized token streams checked against a command-level reference model
module tb_motor_cmd_parser;
  localparam int NM   = 4;
  localparam int MD   = 3;
  localparam int MAXV = 255;
  localparam int TO   = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int nstep = 0;
  always #5 clk = ~clk;
  motor_cmd_if #(.MAX_DIGITS(MD)) bus ();
  motor_cmd_parser #(
    .NUM_MOTORS(NM), .MAX_DIGITS(MD), .MAX_VALUE(MAXV), .TIMEOUT_CYC(TO)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst_n),
    .bus(bus)
  );
  int q[$];
  bit hold;
  int quiet;
  logic e_valid, e_err, e_drop, e_dir;
  logic [3:0] e_motor;
  logic [2:0] e_code;
  int e_bin;
  logic [4*MD-1:0] e_bcd;
  function automatic int value_of_q();
    int v = 0;
    for (int i = 3; i < q.size(); i++) v = v * 10 + q[i];
    return v;
  endfunction
  function automatic int judge(int tok);
    int p = q.size();
    int nd = p - 3;
    if (p == 0) return (tok >= 1 && tok <= NM) ? 0 : 1;
    if (p == 1) return tok == 10 ? 0 : 2;
    if (p == 2) return (tok == 12 || tok == 13) ? 0 : 3;
    if (tok <= 9) return nd == MD ? 5 : 0;
    if (tok == 10 || tok == 11) return nd == 0 ? 4 : (value_of_q() > MAXV ? 6 : 0);
    return 4;
  endfunction
  task automatic model_reset();
    q.delete();
    hold = 0; quiet = 0;
    e_valid = 0; e_err = 0; e_drop = 0; e_dir = 0;
    e_motor = 0; e_code = 0; e_bin = 0; e_bcd = 0;
  endtask
  task automatic model(input logic en, input int tok, input logic rdy);
    int c, v;
    e_err = 0;
    e_drop = 0;
    if (hold) begin
      e_drop = en;
      if (rdy) begin hold = 0; e_valid = 0; end
    end else if (en) begin
      quiet = 0;
      c = judge(tok);
      if (c != 0) begin
        e_err = 1; e_code = 3'(c); q.delete();
      end else if (q.size() >= 4 && (tok == 10 || tok == 11)) begin
        v = value_of_q();
        e_valid = 1; e_motor = 4'(q[0]); e_dir = q[2] == 13; e_bin = v; e_code = 0;
        for (int k = 0; k < MD; k++) e_bcd[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        hold = 1; q.delete();
      end else q.push_back(tok);
    end else if (q.size() > 0) begin
      quiet++;
      if (quiet == TO - 1) begin e_err = 1; e_code = 7; q.delete(); quiet = 0; end
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.o_cmd_valid), 32'(e_valid));
    chk({tag, ".err"},   32'(bus.o_err),       32'(e_err));
    chk({tag, ".code"},  32'(bus.o_err_code),  32'(e_code));
    chk({tag, ".drop"},  32'(bus.o_drop),      32'(e_drop));
    chk({tag, ".idle"},  32'(bus.o_idle),      32'(!hold && q.size() == 0));
    chk({tag, ".motor"}, 32'(bus.o_motor),     32'(e_motor));
    chk({tag, ".dir"},   32'(bus.o_direction), 32'(e_dir));
    chk({tag, ".bcd"},   32'(bus.o_value_bcd), 32'(e_bcd));
    chk({tag, ".bin"},   32'(bus.o_value_bin), 32'(e_bin));
  endtask
  task automatic step(input logic en, input int tok, input logic rdy);
    @(negedge clk);
    bus.i_Enable = en;
    bus.i_Dec = 4'(tok);
    bus.i_cmd_ready = rdy;
    @(posedge clk);
    model(en, tok, rdy);
    nstep++;
    #1;
    check_all($sformatf("s%0d", nstep));
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_Enable = 1'b0;
    bus.i_cmd_ready = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    chk("rst_idle", 32'(bus.o_idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  int toks[$];
  int t, nd;
  initial begin
    bus.i_Enable = 1'b0;
    bus.i_Dec = 4'd0;
    bus.i_cmd_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    rst_n = 1'b1;
    // full command with ENTER terminator
    step(1, 2, 0); step(1, 10, 0); step(1, 13, 0);
    step(1, 1, 0); step(1, 2, 0); step(1, 5, 0); step(1, 11, 0);
    chk("c1_valid", 32'(bus.o_cmd_valid), 32'd1);
    chk("c1_motor", 32'(bus.o_motor), 32'd2);
    chk("c1_dir", 32'(bus.o_direction), 32'd1);
    chk("c1_bcd", 32'(bus.o_value_bcd), 32'h125);
    chk("c1_bin", 32'(bus.o_value_bin), 32'd125);
    step(0, 0, 1);
    // SPACE terminator, held while ready low, token dropped during hold
    step(1, 1, 0); step(1, 10, 0); step(1, 12, 0); step(1, 7, 0); step(1, 10, 0);
    chk("c2_bcd", 32'(bus.o_value_bcd), 32'h007);
    chk("c2_bin", 32'(bus.o_value_bin), 32'd7);
    repeat (5) step(0, 0, 0);
    chk("c2_hold", 32'(bus.o_cmd_valid), 32'd1);
    step(1, 3, 0);
    chk("c2_drop", 32'(bus.o_drop), 32'd1);
    chk("c2_keep", 32'(bus.o_value_bin), 32'd7);
    step(0, 0, 1);
    chk("c2_idle", 32'(bus.o_idle), 32'd1);
    chk("c2_clr", 32'(bus.o_cmd_valid), 32'd0);
    // out of range magnitude
    step(1, 3, 0); step(1, 10, 0); step(1, 12, 0);
    step(1, 3, 0); step(1, 0, 0); step(1, 0, 0); step(1, 10, 0);
    chk("range_err", 32'(bus.o_err), 32'd1);
    chk("range_code", 32'(bus.o_err_code), 32'd6);
    chk("range_valid", 32'(bus.o_cmd_valid), 32'd0);
    // syntax errors
    step(1, 5, 0);
    chk("e1_code", 32'(bus.o_err_code), 32'd1);
    step(1, 1, 0); step(1, 12, 0);
    chk("e2_code", 32'(bus.o_err_code), 32'd2);
    step(1, 1, 0); step(1, 10, 0); step(1, 1, 0);
    chk("e3_code", 32'(bus.o_err_code), 32'd3);
    step(1, 2, 0); step(1, 3, 0); step(1, 4, 0);
    // inter-token timeout
    do_reset();
    step(1, 1, 0); step(1, 10, 0);
    for (int k = 1; k <= 100; k++) begin
      step(0, 0, 0);
      chk($sformatf("tmo_err%0d", k), 32'(bus.o_err), 32'(k == 99));
      if (k == 99) chk("tmo_code", 32'(bus.o_err_code), 32'd7);
    end
    // reset while collecting digits
    step(1, 1, 0); step(1, 10, 0); step(1, 12, 0); step(1, 4, 0);
    do_reset();
    chk("rst_valid", 32'(bus.o_cmd_valid), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    // randomized command streams with occasional corrupted tokens
    for (int n = 0; n < 80; n++) begin
      toks.delete();
      toks.push_back($urandom_range(0, 5));
      toks.push_back(10);
      toks.push_back($urandom_range(12, 13));
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) toks.push_back($urandom_range(0, 9));
      toks.push_back($urandom_range(10, 11));
      foreach (toks[i]) begin
        t = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 15) : toks[i];
        repeat ($urandom_range(0, 2)) step(0, $urandom_range(0, 15), 1'($urandom));
        step(1, t, 1'($urandom));
      end
      repeat ($urandom_range(0, 3)) step(0, 0, 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
